// File: rtl/gate_mon_pkg.sv
// Shared types and constants for the gate delay monitor.
package gate_mon_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      SETTLE,
      REPORT
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK      = 2'd0,
      ERR_TIMEOUT = 2'd1,
      ERR_LIMIT   = 2'd2,
      ERR_GLITCH  = 2'd3
   } err_t;

   localparam logic [7:0] VIOL_MAX = 8'd255;

endpackage

// File: rtl/gate_mon_stats.sv
// Running statistics for the gate delay monitor: worst rise/fall delay and a
// saturating violation count, updated on each result strobe.
module gate_mon_stats
   import gate_mon_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             meas_valid,
   input  logic             meas_dir,
   input  logic [CNT_W-1:0] meas_delay,
   input  logic [1:0]       meas_err,
   output logic [CNT_W-1:0] max_lh,
   output logic [CNT_W-1:0] max_hl,
   output logic [7:0]       viol_cnt
);

   logic track_max;
   logic count_viol;

   // Timeouts and glitches carry no meaningful delay, so only completed measurements feed the maxima.
   assign track_max  = meas_valid && ((meas_err == ERR_OK) || (meas_err == ERR_LIMIT));
   assign count_viol = meas_valid && (meas_err != ERR_OK) && (viol_cnt != VIOL_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         max_lh   <= '0;
         max_hl   <= '0;
         viol_cnt <= '0;
      end else begin
         if (track_max && meas_dir && (meas_delay > max_lh)) begin
            max_lh <= meas_delay;
         end
         if (track_max && !meas_dir && (meas_delay > max_hl)) begin
            max_hl <= meas_delay;
         end
         if (count_viol) begin
            viol_cnt <= viol_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/gate_delay_monitor.sv
// Gate propagation-delay monitor: times the registered gate output against the expected value.
// Optional macro GATE_MON_GLITCH_EN: losing the match while settling reports GLITCH instead of resuming the wait.
//
// state  | meaning
// IDLE   | waiting for stim_valid
// WAIT   | counting cycles until z_q reaches the expected value
// SETTLE | z_q matched; checking it holds for SETTLE cycles
// REPORT | one-cycle result strobe, statistics update
module gate_delay_monitor
   import gate_mon_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int TIMEOUT   = 100,
   parameter int TPDLH_MAX = 5,
   parameter int TPDHL_MAX = 7,
   parameter int SETTLE    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stim_valid,
   input  logic             exp_z,
   input  logic             dut_z,
   output logic             busy,
   output logic             meas_valid,
   output logic             meas_dir,
   output logic [CNT_W-1:0] meas_delay,
   output logic [1:0]       meas_err,
   output logic [CNT_W-1:0] max_lh,
   output logic [CNT_W-1:0] max_hl,
   output logic [7:0]       viol_cnt
);

   state_t           state_q, state_d;
   logic             z_q;
   logic             exp_q, exp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] delay_q, delay_d;
   logic [CNT_W-1:0] stable_q, stable_d;
   logic             meas_load;
   logic             limit_hit;
   err_t             err_d;

   assign limit_hit = exp_q ? (delay_q > CNT_W'(TPDLH_MAX)) : (delay_q > CNT_W'(TPDHL_MAX));

`ifndef GATE_MON_GLITCH_EN
   // After a lost match, keep the cycle count aligned with elapsed time, clamped so it cannot pass TIMEOUT.
   logic [CNT_W:0]   resume_sum;
   logic [CNT_W-1:0] cnt_resume;
   assign resume_sum = {1'b0, delay_q} + {1'b0, stable_q} + (CNT_W+1)'(1);
   assign cnt_resume = (resume_sum >= (CNT_W+1)'(TIMEOUT)) ? CNT_W'(TIMEOUT) : resume_sum[CNT_W-1:0];
`endif

   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      cnt_d     = cnt_q;
      delay_d   = delay_q;
      stable_d  = stable_q;
      err_d     = ERR_OK;
      meas_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (stim_valid) begin
               exp_d = exp_z;
               cnt_d = CNT_W'(1);
               if (z_q == exp_z) begin
                  delay_d  = '0;
                  stable_d = CNT_W'(1);
                  state_d  = gate_mon_pkg::SETTLE;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (z_q == exp_q) begin
               delay_d  = cnt_q;
               stable_d = CNT_W'(1);
               state_d  = gate_mon_pkg::SETTLE;
            end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
               delay_d   = CNT_W'(TIMEOUT);
               err_d     = ERR_TIMEOUT;
               meas_load = 1'b1;
               state_d   = REPORT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         gate_mon_pkg::SETTLE: begin
            if (z_q == exp_q) begin
               if (stable_q == CNT_W'(SETTLE)) begin
                  err_d     = limit_hit ? ERR_LIMIT : ERR_OK;
                  meas_load = 1'b1;
                  state_d   = REPORT;
               end else begin
                  stable_d = stable_q + CNT_W'(1);
               end
            end else begin
`ifdef GATE_MON_GLITCH_EN
               err_d     = ERR_GLITCH;
               meas_load = 1'b1;
               state_d   = REPORT;
`else
               cnt_d   = cnt_resume;
               state_d = WAIT;
`endif
            end
         end
         REPORT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         z_q        <= 1'b0;
         exp_q      <= 1'b0;
         cnt_q      <= '0;
         delay_q    <= '0;
         stable_q   <= '0;
         meas_delay <= '0;
         meas_err   <= '0;
      end else begin
         state_q  <= state_d;
         z_q      <= dut_z;
         exp_q    <= exp_d;
         cnt_q    <= cnt_d;
         delay_q  <= delay_d;
         stable_q <= stable_d;
         if (meas_load) begin
            meas_delay <= delay_d;
            meas_err   <= err_d;
         end
      end
   end

   assign busy       = (state_q != IDLE);
   assign meas_valid = (state_q == REPORT);
   assign meas_dir   = exp_q;

   gate_mon_stats #(
      .CNT_W (CNT_W)
   ) u_stats (
      .clk        (clk),
      .rst        (rst),
      .meas_valid (meas_valid),
      .meas_dir   (meas_dir),
      .meas_delay (meas_delay),
      .meas_err   (meas_err),
      .max_lh     (max_lh),
      .max_hl     (max_hl),
      .viol_cnt   (viol_cnt)
   );

endmodule

// File: tb/tb_gate_delay_monitor.sv
// Directed bench for gate_delay_monitor: the bench plays the gate, driving dut_z on a per-cycle schedule.
module tb_gate_delay_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       stim_valid;
   logic       exp_z;
   logic       dut_z;
   logic       busy;
   logic       meas_valid;
   logic       meas_dir;
   logic [7:0] meas_delay;
   logic [1:0] meas_err;
   logic [7:0] max_lh;
   logic [7:0] max_hl;
   logic [7:0] viol_cnt;

   int checks = 0;
   int errors = 0;

   gate_delay_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .stim_valid (stim_valid),
      .exp_z      (exp_z),
      .dut_z      (dut_z),
      .busy       (busy),
      .meas_valid (meas_valid),
      .meas_dir   (meas_dir),
      .meas_delay (meas_delay),
      .meas_err   (meas_err),
      .max_lh     (max_lh),
      .max_hl     (max_hl),
      .viol_cnt   (viol_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Issue one stimulus at edge 0. dut_z becomes e before edge t1, ~e before t2, e before t3 (-1 = never),
   // so a first match seen by the monitor at edge d needs t1 = d-1. lat = edges from stimulus to strobe.
   task automatic run_meas(input logic e, input int t1, input int t2, input int t3, input bit spam,
                           output int lat, output logic b0);
      lat = -1;
      b0  = 1'b0;
      for (int j = 0; j <= 200; j++) begin
         @(negedge clk);
         stim_valid = (j == 0) || spam;
         exp_z      = (j == 0) ? e : ~e;
         if (j == t1) dut_z = e;
         if (j == t2) dut_z = ~e;
         if (j == t3) dut_z = e;
         @(posedge clk);
         #1;
         if (j == 0) b0 = busy;
         if (meas_valid) begin
            lat = j;
            break;
         end
      end
      if (spam) begin
         @(negedge clk);
         stim_valid = 1'b1;
         exp_z      = ~e;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      stim_valid = 1'b0;
      if (t1 >= 0) dut_z = e;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   lat;
      logic b0;
      int   exp_viol;
      int   pulses;

      rst        = 1'b1;
      stim_valid = 1'b0;
      exp_z      = 1'b0;
      dut_z      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", meas_valid, 0);
      chk("rst_dir", meas_dir, 0);
      chk("rst_delay", meas_delay, 0);
      chk("rst_err", meas_err, 0);
      chk("rst_max_lh", max_lh, 0);
      chk("rst_max_hl", max_hl, 0);
      chk("rst_viol", viol_cnt, 0);
      @(negedge clk);
      rst = 1'b0;

      // Combinational rise: delay 1, strobe 1 + SETTLE + 1 = 4th cycle (edge 3).
      run_meas(1'b1, 0, -1, -1, 1'b0, lat, b0);
      chk("comb_busy", b0, 1);
      chk("comb_lat", lat, 3);
      chk("comb_dir", meas_dir, 1);
      chk("comb_delay", meas_delay, 1);
      chk("comb_err", meas_err, 0);
      chk("comb_max_lh", max_lh, 1);
      chk("comb_viol", viol_cnt, 0);
      chk("comb_valid_off", meas_valid, 0);

      // Already at expected value: delay 0, strobe at edge 2.
      run_meas(1'b1, -1, -1, -1, 1'b0, lat, b0);
      chk("nochg_lat", lat, 2);
      chk("nochg_delay", meas_delay, 0);
      chk("nochg_err", meas_err, 0);
      chk("nochg_max_lh", max_lh, 1);

      // 9-cycle fall exceeds TPDHL_MAX=7.
      run_meas(1'b0, 8, -1, -1, 1'b0, lat, b0);
      chk("fall9_lat", lat, 11);
      chk("fall9_dir", meas_dir, 0);
      chk("fall9_delay", meas_delay, 9);
      chk("fall9_err", meas_err, 2);
      chk("fall9_viol", viol_cnt, 1);
      chk("fall9_max_hl", max_hl, 9);

      // 5-cycle rise sits exactly at TPDLH_MAX.
      run_meas(1'b1, 4, -1, -1, 1'b0, lat, b0);
      chk("rise5_lat", lat, 7);
      chk("rise5_delay", meas_delay, 5);
      chk("rise5_err", meas_err, 0);
      chk("rise5_max_lh", max_lh, 5);
      chk("rise5_viol", viol_cnt, 1);

      run_meas(1'b0, 0, -1, -1, 1'b0, lat, b0);
      chk("fall1_delay", meas_delay, 1);
      chk("fall1_max_hl", max_hl, 9);

      // Output stuck low with a rise expected.
      run_meas(1'b1, -1, -1, -1, 1'b0, lat, b0);
      chk("tmo_lat", lat, 100);
      chk("tmo_delay", meas_delay, 100);
      chk("tmo_err", meas_err, 1);
      chk("tmo_max_lh", max_lh, 5);
      chk("tmo_viol", viol_cnt, 2);

      run_meas(1'b1, 0, -1, -1, 1'b0, lat, b0);
      chk("rise1_max_lh", max_lh, 5);

      // Fall that reaches 0 at edge 3, bounces back at 4, returns at 6; fall limit 7 keeps delay 6 in range.
      exp_viol = 2;
      run_meas(1'b0, 2, 3, 5, 1'b0, lat, b0);
`ifdef GATE_MON_GLITCH_EN
      exp_viol = 3;
      chk("glitch_lat", lat, 4);
      chk("glitch_delay", meas_delay, 3);
      chk("glitch_err", meas_err, 3);
`else
      chk("bounce_lat", lat, 8);
      chk("bounce_delay", meas_delay, 6);
      chk("bounce_err", meas_err, 0);
`endif
      chk("bounce_viol", viol_cnt, exp_viol);
      chk("bounce_max_hl", max_hl, 9);

      // stim_valid held high with the opposite expectation through the whole measurement.
      run_meas(1'b1, 2, -1, -1, 1'b1, lat, b0);
      chk("spam_lat", lat, 5);
      chk("spam_delay", meas_delay, 3);
      chk("spam_dir", meas_dir, 1);
      pulses = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (meas_valid) pulses++;
      end
      chk("spam_extra_pulses", pulses, 0);
      chk("spam_idle", busy, 0);
      chk("spam_viol", viol_cnt, exp_viol);

      // Reset during WAIT.
      @(negedge clk);
      stim_valid = 1'b1;
      exp_z      = 1'b0;
      @(negedge clk);
      stim_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("wait_busy", busy, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_valid", meas_valid, 0);
      chk("abort_dir", meas_dir, 0);
      chk("abort_delay", meas_delay, 0);
      chk("abort_err", meas_err, 0);
      chk("abort_max_lh", max_lh, 0);
      chk("abort_max_hl", max_hl, 0);
      chk("abort_viol", viol_cnt, 0);
      @(negedge clk);
      rst   = 1'b0;
      dut_z = 1'b0;
      pulses = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (meas_valid) pulses++;
      end
      chk("abort_no_pulse", pulses, 0);

      // Violation counter saturation over 260 timeouts.
      for (int i = 1; i <= 260; i++) begin
         run_meas(1'b1, -1, -1, -1, 1'b0, lat, b0);
         if (i == 254) chk("sat_viol_254", viol_cnt, 254);
         if (i == 255) chk("sat_viol_255", viol_cnt, 255);
      end
      chk("sat_viol_260", viol_cnt, 255);
      chk("sat_delay", meas_delay, 100);
      chk("sat_err", meas_err, 1);
      chk("sat_max_lh", max_lh, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
